// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic lamp safety monitor.
// Lamp vectors are {R,Y,G}; fault codes are {illegal, conflict}.
package traffic_pkg;

    typedef enum logic [1:0] {
        StPass    = 2'd0,
        StPend    = 2'd1,
        StFlash   = 2'd2,
        StRecover = 2'd3
    } state_e;

    localparam int unsigned LampR = 2;
    localparam int unsigned LampY = 1;
    localparam int unsigned LampG = 0;

    localparam logic [1:0] FcNone = 2'b00;
    localparam logic [1:0] FcConf = 2'b01;
    localparam logic [1:0] FcIll  = 2'b10;
    localparam logic [1:0] FcBoth = 2'b11;

    localparam logic [2:0] AspRed = 3'b100;
    localparam logic [2:0] AspYlw = 3'b010;
    localparam logic [2:0] AspGrn = 3'b001;
    localparam logic [2:0] AspOff = 3'b000;

    function automatic logic is_one_hot(input logic [2:0] asp);
        return (asp == AspRed) || (asp == AspYlw) || (asp == AspGrn);
    endfunction

endpackage

// File: rtl/flash_timer.sv
// Flash phase generator: phase_o is the lamp phase (1 = ON) for the next cycle.
// Restarts at count 0 / phase ON whenever en_i is low.
module flash_timer #(
    parameter int unsigned FLASH_DIV = 8
) (
    input  logic CK,
    input  logic CLR,
    input  logic en_i,
    output logic phase_o
);

    localparam int unsigned DW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;
    localparam logic [DW-1:0] DivLast = DW'(FLASH_DIV - 1);

    logic [DW-1:0] cnt_q;
    logic          phase_q;

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (!en_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (cnt_q == DivLast) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign phase_o = (en_i && (cnt_q == DivLast)) ? ~phase_q : phase_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Safety stage between the traffic-light controller and the physical lamps: forwards legal
// aspects, filters transient faults, latches flashing red on persistent faults.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned FILTER_CYC  = 3,
    parameter int unsigned FLASH_DIV   = 8,
    parameter int unsigned RECOVER_CYC = 16
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       GRN1,
    input  logic       YLW1,
    input  logic       RED1,
    input  logic       GRN2,
    input  logic       YLW2,
    input  logic       RED2,
    input  logic       ACK,
    output logic [2:0] LAMP1,
    output logic [2:0] LAMP2,
    output logic       FAULT,
    output logic [1:0] FAULT_CODE,
    output logic       FLASH
);

    localparam int unsigned CntMax = (FILTER_CYC > RECOVER_CYC) ? FILTER_CYC : RECOVER_CYC;
    localparam int unsigned CW     = $clog2(CntMax) + 1;
    localparam logic [CW-1:0] FiltLast = CW'(FILTER_CYC - 1);
    localparam logic [CW-1:0] RecLast  = CW'(RECOVER_CYC - 1);
    localparam logic [CW-1:0] CntSat   = '1;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    lamp1_q, lamp2_q;
    logic          fault_q, flash_q;
    logic [1:0]    code_q;

    logic [2:0]    asp1, asp2;
    logic          bad_conf, bad_ill, bad;
    logic [1:0]    code;
    logic [CW-1:0] cnt_inc;
    logic          phase;

    always_comb begin
        asp1        = AspOff;
        asp2        = AspOff;
        asp1[LampR] = RED1;
        asp1[LampY] = YLW1;
        asp1[LampG] = GRN1;
        asp2[LampR] = RED2;
        asp2[LampY] = YLW2;
        asp2[LampG] = GRN2;
        bad_conf    = !RED1 && !RED2;
        bad_ill     = !is_one_hot(asp1) || !is_one_hot(asp2);
        code        = (bad_ill ? FcIll : FcNone) | (bad_conf ? FcConf : FcNone);
        bad         = bad_conf || bad_ill;
        cnt_inc     = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
    end

    flash_timer #(
        .FLASH_DIV (FLASH_DIV)
    ) u_flash_timer (
        .CK      (CK),
        .CLR     (CLR),
        .en_i    (state_q == StFlash),
        .phase_o (phase)
    );

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state_q <= StRecover;
            cnt_q   <= '0;
            lamp1_q <= AspRed;
            lamp2_q <= AspRed;
            fault_q <= 1'b0;
            code_q  <= FcNone;
            flash_q <= 1'b0;
        end else begin
            case (state_q)
                StPass: begin
                    if (!bad) begin
                        lamp1_q <= asp1;
                        lamp2_q <= asp2;
                    end else if (FILTER_CYC == 1) begin
                        state_q <= StFlash;
                        cnt_q   <= '0;
                        lamp1_q <= AspRed;
                        lamp2_q <= AspRed;
                        fault_q <= 1'b1;
                        flash_q <= 1'b1;
                        code_q  <= code;
                    end else begin
                        // Lamps keep the last legal aspect while the fault is filtered.
                        state_q <= StPend;
                        cnt_q   <= CW'(1);
                        code_q  <= code;
                    end
                end
                StPend: begin
                    if (!bad) begin
                        state_q <= StPass;
                        cnt_q   <= '0;
                        lamp1_q <= asp1;
                        lamp2_q <= asp2;
                        code_q  <= FcNone;
                    end else if (cnt_q == FiltLast) begin
                        state_q <= StFlash;
                        cnt_q   <= '0;
                        lamp1_q <= AspRed;
                        lamp2_q <= AspRed;
                        fault_q <= 1'b1;
                        flash_q <= 1'b1;
                        code_q  <= code_q | code;
                    end else begin
                        cnt_q   <= cnt_inc;
                        code_q  <= code_q | code;
                    end
                end
                StFlash: begin
                    if (ACK && !bad) begin
                        state_q <= StRecover;
                        cnt_q   <= '0;
                        lamp1_q <= AspRed;
                        lamp2_q <= AspRed;
                        flash_q <= 1'b0;
                    end else begin
                        lamp1_q <= phase ? AspRed : AspOff;
                        lamp2_q <= phase ? AspRed : AspOff;
                    end
                end
                StRecover: begin
                    if (bad) begin
                        state_q <= StFlash;
                        cnt_q   <= '0;
                        lamp1_q <= AspRed;
                        lamp2_q <= AspRed;
                        fault_q <= 1'b1;
                        flash_q <= 1'b1;
                        code_q  <= code;
                    end else if (cnt_q == RecLast) begin
                        state_q <= StPass;
                        cnt_q   <= '0;
                        lamp1_q <= asp1;
                        lamp2_q <= asp2;
                        fault_q <= 1'b0;
                        code_q  <= FcNone;
                    end else begin
                        cnt_q   <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= StFlash;
                    cnt_q   <= '0;
                    lamp1_q <= AspRed;
                    lamp2_q <= AspRed;
                    fault_q <= 1'b1;
                    flash_q <= 1'b1;
                    code_q  <= FcBoth;
                end
            endcase
        end
    end

    assign LAMP1      = lamp1_q;
    assign LAMP2      = lamp2_q;
    assign FAULT      = fault_q;
    assign FAULT_CODE = code_q;
    assign FLASH      = flash_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Scoreboard bench for traffic_lamp_monitor: expected outputs are queued as each cycle's
// inputs are driven and compared once the clock edge has produced the DUT response.
module tb_traffic_lamp_monitor;

    logic       CK = 1'b0;
    logic       CLR;
    logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK;
    logic [2:0] LAMP1, LAMP2;
    logic       FAULT, FLASH;
    logic [1:0] FAULT_CODE;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned fi       = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    // Input patterns {R1,Y1,G1,R2,Y2,G2}
    localparam logic [5:0] InA    = 6'b100_001;
    localparam logic [5:0] InB    = 6'b001_100;
    localparam logic [5:0] InConf = 6'b001_001;
    localparam logic [5:0] InIll  = 6'b110_100;
    localparam logic [5:0] InOff2 = 6'b100_000;
    localparam logic [8:0] ResetV = {3'b100, 3'b100, 1'b0, 2'b00, 1'b0};

    traffic_lamp_monitor dut (
        .CK         (CK),
        .CLR        (CLR),
        .GRN1       (GRN1),
        .YLW1       (YLW1),
        .RED1       (RED1),
        .GRN2       (GRN2),
        .YLW2       (YLW2),
        .RED2       (RED2),
        .ACK        (ACK),
        .LAMP1      (LAMP1),
        .LAMP2      (LAMP2),
        .FAULT      (FAULT),
        .FAULT_CODE (FAULT_CODE),
        .FLASH      (FLASH)
    );

    always #5 CK = ~CK;

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got L1=%b L2=%b F=%b C=%b FL=%b exp L1=%b L2=%b F=%b C=%b FL=%b",
                     tag, got[8:6], got[5:3], got[2], got[1:0], got[0],
                     exp[8:6], exp[5:3], exp[2], exp[1:0], exp[0]);
        end
    endtask

    task automatic cyc(input string tag, input logic [5:0] in, input logic ack,
                       input logic [2:0] l1, input logic [2:0] l2, input logic f,
                       input logic [1:0] c, input logic fl);
        {RED1, YLW1, GRN1, RED2, YLW2, GRN2} = in;
        ACK = ack;
        exp_q.push_back({l1, l2, f, c, fl});
        tag_q.push_back(tag);
        @(posedge CK);
        #1;
        check_eq(tag_q.pop_front(), {LAMP1, LAMP2, FAULT, FAULT_CODE, FLASH}, exp_q.pop_front());
    endtask

    // Stay in FLASH for n cycles; fi counts cycles since flash entry (entry cycle = 0).
    task automatic flash_run(input string tag, input logic [5:0] in, input logic ack,
                             input int n, input logic [1:0] c);
        logic [2:0] l;
        for (int i = 0; i < n; i++) begin
            l = (((fi / 8) % 2) == 0) ? 3'b100 : 3'b000;
            cyc(tag, in, ack, l, l, 1'b1, c, 1'b1);
            fi++;
        end
    endtask

    initial begin
        CLR = 1'b1;
        {RED1, YLW1, GRN1, RED2, YLW2, GRN2} = InA;
        ACK = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        check_eq("reset", {LAMP1, LAMP2, FAULT, FAULT_CODE, FLASH}, ResetV);
        CLR = 1'b0;

        // Start-up recovery interval, then forwarding
        for (int i = 0; i < 15; i++) cyc("startup", InA, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00, 1'b0);
        cyc("startup_pass", InA, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00, 1'b0);

        // Two-cycle conflict is filtered
        cyc("fwd_b", InB, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, 1'b0);
        cyc("pend1", InConf, 1'b0, 3'b001, 3'b100, 1'b0, 2'b01, 1'b0);
        cyc("pend2", InConf, 1'b0, 3'b001, 3'b100, 1'b0, 2'b01, 1'b0);
        cyc("pend_exit", InA, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00, 1'b0);

        // Three-cycle conflict latches flashing red
        cyc("conf1", InConf, 1'b0, 3'b100, 3'b001, 1'b0, 2'b01, 1'b0);
        cyc("conf2", InConf, 1'b0, 3'b100, 3'b001, 1'b0, 2'b01, 1'b0);
        cyc("flash_entry", InConf, 1'b0, 3'b100, 3'b100, 1'b1, 2'b01, 1'b1);
        fi = 1;
        flash_run("flash_conf", InConf, 1'b0, 20, 2'b01);

        // ACK while still bad is ignored; ACK with legal inputs starts recovery
        flash_run("ack_ill", InIll, 1'b1, 3, 2'b01);
        cyc("ack_ok", InA, 1'b1, 3'b100, 3'b100, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 15; i++) cyc("recover", InA, 1'b0, 3'b100, 3'b100, 1'b1, 2'b01, 1'b0);
        cyc("recover_done", InA, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00, 1'b0);
        cyc("ack_pass", InA, 1'b1, 3'b100, 3'b001, 1'b0, 2'b00, 1'b0);

        // Mixed causes accumulate to code 11
        cyc("acc1", InIll, 1'b0, 3'b100, 3'b001, 1'b0, 2'b10, 1'b0);
        cyc("acc2", InConf, 1'b0, 3'b100, 3'b001, 1'b0, 2'b11, 1'b0);
        cyc("acc3", InIll, 1'b0, 3'b100, 3'b100, 1'b1, 2'b11, 1'b1);
        fi = 1;
        flash_run("flash_both", InIll, 1'b0, 4, 2'b11);
        cyc("ack2", InA, 1'b1, 3'b100, 3'b100, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) cyc("rec2", InA, 1'b0, 3'b100, 3'b100, 1'b1, 2'b11, 1'b0);

        // Dark approach 2 during recovery re-latches an illegal-aspect fault
        cyc("rec_bad", InOff2, 1'b0, 3'b100, 3'b100, 1'b1, 2'b10, 1'b1);
        fi = 1;
        flash_run("flash_ill", InOff2, 1'b0, 10, 2'b10);

        // Asynchronous clear mid-flash (currently in the OFF phase)
        #3;
        CLR = 1'b1;
        #1;
        check_eq("async_clr", {LAMP1, LAMP2, FAULT, FAULT_CODE, FLASH}, ResetV);
        @(posedge CK);
        #1;
        CLR = 1'b0;
        for (int i = 0; i < 15; i++) cyc("restart", InB, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00, 1'b0);
        cyc("restart_pass", InB, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
